mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit, sitting between the register-file read ports and the register-file write port.
- Consumes the rs1/rs2 operand values and the destination index, computes over n cycles, then presents the result and write-enable that drive the register file's Wr_data/Wr_en/rd inputs.
- Iterative shift-add multiply and restoring divide, sharing one 2n-bit working register.

Parameters:
n, 32, operand/result width (XLEN); must be even and >= 8.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled only when idle or in the done cycle.
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_data  input  n  operand A (dividend / multiplicand).
rs2_data  input  n  operand B (divisor / multiplier).
rd_in  input  5  destination register index.
flush  input  1  synchronous abort of the in-flight op.
busy  output  1  high while computing.
done  output  1  one-cycle pulse when result is valid.
wr_en  output  1  equals done AND (rd_out != 0).
rd_out  output  5  latched destination index.
result  output  n  final result; held until the next done.

Behaviour:
- Async reset (rst=0), effective immediately including mid-operation:
  - state=IDLE; busy, done, wr_en = 0; result = 0; rd_out = 0; counter cleared.
- States: IDLE, CALC, DONE.
  - IDLE->CALC on start=1: latch funct3, rd_in, |rs1_data|, |rs2_data| (signed ops take magnitudes; MULHSU takes the magnitude of A only) and the result sign; counter = n-1.
  - CALC: one bit per cycle, busy=1. Decrement counter. On counter==0, go to DONE.
  - DONE: single cycle. done=1, busy=0, wr_en=(rd_out!=0), result register updated.
  - DONE->CALC if start=1 (back-to-back accepted); otherwise DONE->IDLE.
- Latency: start high in cycle 0 gives busy high in cycles 1..n and done/wr_en high in cycle n+1. Throughput is one op per n+1 cycles.
- start while in CALC is ignored; no queueing.
- flush=1 in CALC or DONE:
  - Next state IDLE.
  - done/wr_en are forced 0 in that cycle.
  - result and rd_out are not updated.
  - flush has priority over start.
- Arithmetic:
  - MUL returns the low n bits of the product.
  - MULH/MULHSU/MULHU return the high n bits (signed x signed, signed x unsigned, unsigned x unsigned).
  - Signed results are negated after the final iteration when the sign flag is set (2n-bit two's complement).
  - DIV/DIVU return the quotient, truncated toward zero; REM/REMU return the remainder, which takes the sign of the dividend.
- Boundary cases, with full latency preserved:
  - Divide by zero: quotient = all ones (0xFFFFFFFF for both DIV and DIVU); remainder = rs1_data.
  - Signed overflow (-2^(n-1) / -1): quotient = -2^(n-1); remainder = 0.
  - rd_in = 0: computation proceeds, done pulses, wr_en stays 0.
- Operand inputs are sampled only at acceptance; later changes have no effect.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: divide-by-zero, signed overflow, and any multiply with a zero operand are detected at acceptance. State goes CALC for one cycle, then DONE, so done is asserted in cycle 2. Results are identical to the full-latency path.
- Undefined: every op takes exactly n+1 cycles. No early-out logic is generated.

Test Plan:
1. MUL: rs1=7, rs2=0xFFFFFFFD (-3), rd_in=5, start in cycle 0 -> busy cycles 1..32; cycle 33: done=1, wr_en=1, rd_out=5, result=0xFFFFFFEB.
2. MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. With MDU_EARLY_OUT_EN, done is asserted in cycle 2.
5. Reset and flush:
   - rst=0 in cycle 10 of a DIV -> busy/done/wr_en/result immediately 0.
   - After release, a new start completes normally.
   - flush=1 in cycle 20 -> no done pulse, and result keeps its previous value.
6. Back-to-back and ignored start:
   - start held high across the DONE cycle with rd_in=0 -> first op gives done=1 with wr_en=0.
   - Second op accepted in the same cycle -> its done arrives 33 cycles later.
   - start pulses during CALC -> ignored.

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: RV32M multiply/divide unit. Shift-add multiply and restoring divide share one 2n-bit register.
// Optional macro MDU_EARLY_OUT_EN: trivial cases (divide by zero, signed overflow, zero multiply operand) finish in two cycles.
// Revision: 1.0
`default_nettype none

module mdu_iterative #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] rs1_data,
  input  logic [n-1:0] rs2_data,
  input  logic [4:0]   rd_in,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         wr_en,
  output logic [4:0]   rd_out,
  output logic [n-1:0] result
);

  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_q, neg_d;
  logic [n-1:0]     opnd_q, opnd_d;
  logic [2*n-1:0]   work_q, work_d;
  logic [n-1:0]     res_q, res_d;
`ifdef MDU_EARLY_OUT_EN
  logic             early_q, early_d;
  logic             div_zero, sgn_ovf, mul_zero;
`endif

  logic             a_signed, b_signed, sign_a, sign_b, accept;
  logic [n-1:0]     mag_a, mag_b, div_sel, final_res;
  logic [n:0]       mul_sum, div_trial;
  logic [2*n-1:0]   step, prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    res_d   = res_q;
`ifdef MDU_EARLY_OUT_EN
    early_d = early_q;
`endif

    busy  = (state_q == S_CALC);
    done  = (state_q == S_DONE) && !flush;
    wr_en = done && (rd_q != 5'd0);

    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a   = a_signed && rs1_data[n-1];
    sign_b   = b_signed && rs2_data[n-1];
    mag_a    = sign_a ? -rs1_data : rs1_data;
    mag_b    = sign_b ? -rs2_data : rs2_data;

    // Multiply: {acc, multiplier} shifts right; divide: {rem, quotient} shifts left.
    mul_sum   = {1'b0, work_q[2*n-1:n]} + (work_q[0] ? {1'b0, opnd_q} : {(n+1){1'b0}});
    div_trial = work_q[2*n-1:n-1] - {1'b0, opnd_q};
    if (op_q[2]) begin
      step = div_trial[n] ? {work_q[2*n-2:0], 1'b0}
                          : {div_trial[n-1:0], work_q[n-2:0], 1'b1};
    end else begin
      step = {mul_sum, work_q[n-1:1]};
    end

    prod    = neg_q ? -step : step;
    div_sel = op_q[1] ? step[2*n-1:n] : step[n-1:0];
    if (op_q[2]) begin
      final_res = neg_q ? -div_sel : div_sel;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod[n-1:0] : prod[2*n-1:n];
    end
`ifdef MDU_EARLY_OUT_EN
    if (early_q) begin
      final_res = work_q[n-1:0];
    end
    div_zero = funct3[2] && (rs2_data == '0);
    sgn_ovf  = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(n-1){1'b0}}}) && (rs2_data == '1);
    mul_zero = !funct3[2] && ((rs1_data == '0) || (rs2_data == '0));
`endif

    accept = start && ((state_q == S_IDLE) || ((state_q == S_DONE) && !flush));

    case (state_q)
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          work_d = step;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            res_d   = final_res;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        if (accept) begin
          state_d = S_CALC;
          op_d    = funct3;
          rd_d    = rd_in;
          cnt_d   = CW'(n-1);
          if (funct3[2]) begin
            opnd_d = mag_b;
            work_d = {{n{1'b0}}, mag_a};
            // A zero divisor must yield an all-ones quotient regardless of operand signs.
            neg_d  = funct3[1] ? sign_a : ((sign_a ^ sign_b) && (rs2_data != '0));
          end else begin
            opnd_d = mag_a;
            work_d = {{n{1'b0}}, mag_b};
            neg_d  = sign_a ^ sign_b;
          end
`ifdef MDU_EARLY_OUT_EN
          early_d = div_zero || sgn_ovf || mul_zero;
          if (div_zero || sgn_ovf || mul_zero) begin
            cnt_d = '0;
            neg_d = 1'b0;
            if (div_zero) begin
              work_d = {{n{1'b0}}, (funct3[1] ? rs1_data : {n{1'b1}})};
            end else if (sgn_ovf) begin
              work_d = {{n{1'b0}}, (funct3[1] ? {n{1'b0}} : rs1_data)};
            end else begin
              work_d = '0;
            end
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      work_q  <= '0;
      res_q   <= '0;
`ifdef MDU_EARLY_OUT_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      res_q   <= res_d;
`ifdef MDU_EARLY_OUT_EN
      early_q <= early_d;
`endif
    end
  end

  assign rd_out = rd_q;
  assign result = res_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed table, randomized ops against an arithmetic reference model, and reset/flush/back-to-back sequences.
// Revision: 1.0
`default_nettype none

module tb_mdu_iterative;
  localparam int N   = 32;
  localparam int LAT = N + 1;

  logic          clk = 1'b0;
  logic          rst_n, start, flush;
  logic [2:0]    funct3;
  logic [N-1:0]  rs1, rs2;
  logic [4:0]    rd_in;
  logic          busy, done, wr_en;
  logic [4:0]    rd_out;
  logic [N-1:0]  result;

  int checks = 0;
  int errors = 0;

  mdu_iterative #(.n(N)) dut (
    .clk(clk), .rst(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1), .rs2_data(rs2), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .wr_en(wr_en), .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sp = sa / sb;
        return sp[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sp = sa % sb;
        return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (!f3[2] && (a == 0 || b == 0)) return 1'b1;
    if (f3[2] && b == 0) return 1'b1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
`else
    return (f3 == 3'd7) && (a != a) && (b != b);
`endif
  endfunction

  // Called one cycle after acceptance; counts that cycle as 1.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= LAT + 10; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat, bcnt, exp_lat;
    funct3 = f3; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    rs1    = $urandom;
    rs2    = $urandom;
    rd_in  = 5'($urandom);
    wait_done(lat, bcnt);
    exp_lat = is_early(f3, a, b) ? 2 : LAT;
    chk({tag, " result"}, 64'(result), 64'(exp));
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    chk({tag, " busy_in_done"}, 64'(busy), 64'(0));
    chk({tag, " wr_en"}, 64'(wr_en), 64'(rd != 5'd0));
    chk({tag, " rd_out"}, 64'(rd_out), 64'(rd));
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [2:0]  f3;
    logic [31:0] a, b;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2};
    tbl[8]  = '{3'd5, 32'h1234,       32'd0,         5'd9,  32'hFFFF_FFFF};
    tbl[9]  = '{3'd6, 32'h1234,       32'd0,         5'd10, 32'h1234};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0};
    tbl[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         5'd13, 32'hFFFF_FFFF};
    tbl[13] = '{3'd7, 32'hFFFF_FFF9,  32'd0,         5'd0,  32'hFFFF_FFF9};
    tbl[14] = '{3'd0, 32'd0,          32'd12345,     5'd14, 32'h0};
    tbl[15] = '{3'd1, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 5'd15, 32'hFFFF_FFFF};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset wr_en", 64'(wr_en), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    chk("reset rd_out", 64'(rd_out), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom), model(f3, a, b));
    end

    // Asynchronous reset in cycle 10 of a divide.
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst wr_en", 64'(wr_en), 64'(0));
    chk("midrst result", 64'(result), 64'(0));
    chk("midrst rd_out", 64'(rd_out), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst idle", 64'(busy), 64'(0));
    do_op("postrst", 3'd5, 32'd1000, 32'd3, 5'd4, 32'd333);

    // Flush in cycle 20 of a divide: no done, result retained.
    funct3 = 3'd4; rs1 = 32'hFFFF_FF00; rs2 = 32'd5; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("flush no_done", 64'(dcnt), 64'(0));
    chk("flush result_kept", 64'(result), 64'(333));
    chk("flush idle", 64'(busy), 64'(0));

    // Flush in the done cycle masks done and beats a simultaneous start.
    do_op("pre_flush_done", 3'd0, 32'd6, 32'd7, 5'd2, 32'd42);
    flush = 1'b1; start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd3;
    #1;
    chk("flushdone done", 64'(done), 64'(0));
    chk("flushdone wr_en", 64'(wr_en), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flushdone no_accept", 64'(busy), 64'(0));
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("flushdone no_done", 64'(dcnt), 64'(0));
    chk("flushdone result", 64'(result), 64'(42));

    // Start pulses during CALC are ignored.
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'd3; rs1 = '1; rs2 = '1; rd_in = 5'd9;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ignstart latency", 64'(lat), 64'(LAT - 15));
    chk("ignstart result", 64'(result), 64'(142));
    chk("ignstart rd_out", 64'(rd_out), 64'(3));

    // Back-to-back with start held high; first op targets x0.
    @(posedge clk); #1;
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_in = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9;
    wait_done(lat, bcnt);
    chk("b2b first latency", 64'(lat), 64'(LAT));
    chk("b2b first result", 64'(result), 64'(12));
    chk("b2b first done", 64'(done), 64'(1));
    chk("b2b first wr_en", 64'(wr_en), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b second latency", 64'(lat), 64'(LAT));
    chk("b2b second result", 64'(result), 64'(14));
    chk("b2b second wr_en", 64'(wr_en), 64'(1));
    chk("b2b second rd_out", 64'(rd_out), 64'(9));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
